// File: rtl/lfsr_mod_ctrl.sv
// rtl/lfsr_mod_ctrl.sv - LFSR-driven symbol modulator (ASK/FSK/BPSK/RAW)
//
// Purpose: latches a symbol bit from an external LFSR on each symbol strobe and
// uses it to modulate a DDS carrier. The mode is selected per symbol. In FSK
// mode the block steers the upstream DDS through its phase increment.
//
// Ports:
//   clk          in   1   rising-edge clock
//   reset        in   1   asynchronous active-low reset
//   lfsr_q       in   5   LFSR state, bit 0 is the symbol bit
//   sym_tick     in   1   symbol boundary strobe
//   mod_sel      in   2   requested mode: 00 ASK, 01 FSK, 10 BPSK, 11 RAW
//   carrier_in   in  12   signed carrier sample
//   sample_valid in   1   carrier_in valid
//   mod_out      out 12   signed modulated sample (registered)
//   mod_valid    out  1   mod_out valid (registered)
//   phase_inc    out 32   DDS phase increment (registered)
//   sym_bit      out  1   active symbol bit
//   active_mode  out  2   active mode
//   sym_count    out 16   symbols latched since reset (wraps)
module lfsr_mod_ctrl #(
    parameter logic [31:0] INC_LO = 32'd258,
    parameter logic [31:0] INC_HI = 32'd2577
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [4:0]         lfsr_q,
    input  logic               sym_tick,
    input  logic [1:0]         mod_sel,
    input  logic signed [11:0] carrier_in,
    input  logic               sample_valid,
    output logic signed [11:0] mod_out,
    output logic               mod_valid,
    output logic [31:0]        phase_inc,
    output logic               sym_bit,
    output logic [1:0]         active_mode,
    output logic [15:0]        sym_count
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] MODE_ASK  = 2'b00;
    localparam logic [1:0] MODE_FSK  = 2'b01;
    localparam logic [1:0] MODE_BPSK = 2'b10;
    localparam logic [1:0] MODE_RAW  = 2'b11;

    localparam logic signed [11:0] S_MAX = 12'sh7FF;
    localparam logic signed [11:0] S_MIN = 12'sh800;

    state_t             r_state;
    logic signed [11:0] r_mod_out;
    logic               r_mod_valid;
    logic [31:0]        r_phase_inc;
    logic               r_sym_bit;
    logic [1:0]         r_active_mode;
    logic [15:0]        r_sym_count;

    logic signed [11:0] w_neg_carrier;
    logic signed [11:0] w_mod_next;

    // Two's-complement negation of -2048 would wrap back to -2048; clamp it.
    always_comb begin
        w_neg_carrier = -carrier_in;
        if (carrier_in == S_MIN) begin
            w_neg_carrier = S_MAX;
        end
    end

    // Uses the registered symbol/mode, so a sample arriving together with a
    // sym_tick is still modulated with the previous symbol.
    always_comb begin
        w_mod_next = carrier_in;
        case (r_active_mode)
            MODE_ASK:  w_mod_next = r_sym_bit ? carrier_in : 12'sd0;
            MODE_FSK:  w_mod_next = carrier_in;
            MODE_BPSK: w_mod_next = r_sym_bit ? carrier_in : w_neg_carrier;
            MODE_RAW:  w_mod_next = r_sym_bit ? S_MAX : S_MIN;
            default:   w_mod_next = carrier_in;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_mod_out     <= 12'sd0;
            r_mod_valid   <= 1'b0;
            r_phase_inc   <= INC_LO;
            r_sym_bit     <= 1'b0;
            r_active_mode <= MODE_ASK;
            r_sym_count   <= 16'd0;
        end else begin
            if (sym_tick) begin
                r_sym_bit     <= lfsr_q[0];
                r_active_mode <= mod_sel;
                r_sym_count   <= r_sym_count + 16'd1;
            end

            case (r_state)
                IDLE: begin
                    r_mod_valid <= 1'b0;
                    r_phase_inc <= INC_LO;
                    if (sym_tick) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_mod_valid <= sample_valid;
                    if (sample_valid) begin
                        r_mod_out <= w_mod_next;
                    end
                    // Follows the latched symbol one cycle after the tick.
                    if (r_active_mode == MODE_FSK && r_sym_bit) begin
                        r_phase_inc <= INC_HI;
                    end else begin
                        r_phase_inc <= INC_LO;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mod_out     = r_mod_out;
    assign mod_valid   = r_mod_valid;
    assign phase_inc   = r_phase_inc;
    assign sym_bit     = r_sym_bit;
    assign active_mode = r_active_mode;
    assign sym_count   = r_sym_count;

endmodule

// File: doc/lfsr_mod_ctrl.md
LFSR_MOD_CTRL -- requirements
Module: lfsr_mod_ctrl

Interface
REQ-001 Parameter INC_LO, default 32'd258: DDS phase increment for FSK symbol 0.
REQ-002 Parameter INC_HI, default 32'd2577: DDS phase increment for FSK symbol 1.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 lfsr_q  input  5  current LFSR state; bit 0 is the symbol bit.
REQ-006 sym_tick  input  1  one-cycle strobe marking a symbol boundary (LFSR advance).
REQ-007 mod_sel  input  2  requested mode: 00 ASK, 01 FSK, 10 BPSK, 11 RAW.
REQ-008 carrier_in  input  12  signed two's-complement DDS carrier sample.
REQ-009 sample_valid  input  1  carrier_in valid this cycle.
REQ-010 mod_out  output  12  signed modulated sample, registered.
REQ-011 mod_valid  output  1  mod_out valid, registered.
REQ-012 phase_inc  output  32  phase increment for the upstream DDS, registered.
REQ-013 sym_bit  output  1  currently active symbol bit.
REQ-014 active_mode  output  2  mode currently applied.
REQ-015 sym_count  output  16  number of symbols latched since reset.

Function
REQ-016 The block SHALL implement FSM states IDLE, RUN; IDLE after reset.
REQ-017 In IDLE: mod_valid SHALL stay 0 and sample_valid SHALL be ignored.
REQ-018 IDLE->RUN SHALL occur on the first sym_tick; that edge latches the first symbol.
REQ-019 On each sym_tick edge (IDLE or RUN): sym_bit <= lfsr_q[0], active_mode <= mod_sel, sym_count <= sym_count+1.
REQ-020 sym_count SHALL wrap 16'hFFFF -> 16'h0000 without flag.
REQ-021 mod_sel changes between ticks SHALL have no effect until the next sym_tick.
REQ-022 In RUN, on sample_valid: mod_out SHALL be computed from carrier_in, sym_bit, active_mode as they stand before that edge; mod_valid=1 the next cycle (latency 1).
REQ-023 mod_valid SHALL be 0 in any cycle following a cycle with sample_valid=0; mod_out SHALL hold its last value.
REQ-024 ASK: mod_out = sym_bit ? carrier_in : 0.
REQ-025 FSK: mod_out = carrier_in; phase_inc = sym_bit ? INC_HI : INC_LO.
REQ-026 BPSK: mod_out = sym_bit ? carrier_in : -carrier_in; -(-2048) SHALL saturate to +2047.
REQ-027 RAW: mod_out = sym_bit ? 12'sd2047 : -12'sd2048, independent of carrier_in.
REQ-028 In non-FSK modes and in IDLE, phase_inc SHALL equal INC_LO.
REQ-029 phase_inc SHALL update on the cycle after the sym_tick edge that changes sym_bit/active_mode (one cycle after the latch).
REQ-030 Simultaneous sym_tick and sample_valid: the sample SHALL use the old sym_bit/active_mode; the new ones apply from the next sample.
REQ-031 sym_tick asserted on consecutive cycles SHALL latch a symbol on each cycle.

Reset
REQ-032 Asserting reset (0) SHALL immediately, asynchronously, force: state IDLE, mod_out 0, mod_valid 0, phase_inc INC_LO, sym_bit 0, active_mode 00, sym_count 0.
REQ-033 Reset mid-operation SHALL discard any in-flight sample; after release, the block behaves as after power-up, waiting for sym_tick.
REQ-034 Reset release SHALL take effect on the first clk edge after reset returns to 1.

Verification
REQ-035 Reset, then 10 sample_valid pulses with no sym_tick -> mod_valid stays 0, sym_count=0, phase_inc=258.
REQ-036 mod_sel=10, lfsr_q=5'b00000, sym_tick, then carrier_in=-2048, sample_valid -> mod_out=+2047, mod_valid=1 one cycle later; carrier_in=100 -> -100.
REQ-037 mod_sel=01, sym_tick with lfsr_q[0]=1 -> phase_inc=2577 one cycle after tick; next tick with lfsr_q[0]=0 -> 258.
REQ-038 Change mod_sel 00->11 between ticks -> active_mode stays 00 until next sym_tick; sample then yields +2047/-2048 per sym_bit.
REQ-039 sym_tick and sample_valid in the same cycle, sym_bit 0->1 in ASK -> that sample gives mod_out=0, next sample gives carrier_in.
REQ-040 Preload by 65535 ticks, one more tick -> sym_count=0; assert reset mid-RUN -> all outputs at reset values immediately, without a clock edge.
